rename: RTL and testbench
=========================

# rename

Register-rename stage for the out-of-order core. Maps 5-bit architectural registers onto a 64-entry physical register file and allocates a fresh physical tag for every instruction that writes a nonzero destination. Tracks ready/value state per physical register, and updates it on writeback wakeups with same-cycle bypass. Sits between decode and dispatch; freed tags come back from commit.

## Interface
- No parameters. Sizes are fixed: 32 architectural registers, 64 physical registers, 32-bit data.
- clk  in  1  Single clock; all state updates on the rising edge.
- reset  in  1  Asynchronous, active-high; restores the reset state immediately.
- wakeup_active  in  1  A writeback is completing this cycle.
- wakeup_tag  in  6  Physical tag being written back.
- wakeup_value  in  32  Result value for wakeup_tag.
- freed_tag_1  in  6  Tag returned to the free list; 0 means none.
- freed_tag_2  in  6  Second returned tag; 0 means none.
- architectural_rd  in  5  Destination of the instruction presented this cycle; 0 means no destination.
- architectural_rs1  in  5  Source 1.
- architectural_rs2  in  5  Source 2.
- physical_rd  out  6  Tag allocated for rd; 0 when rd = 0 or no tag is free.
- physical_rs1  out  6  Current mapping of rs1.
- physical_rs2  out  6  Current mapping of rs2.
- rs1_ready  out  1  Value of physical_rs1 is available.
- rs2_ready  out  1  Value of physical_rs2 is available.
- rs1_value  out  32  Value of physical_rs1; 0 when not ready.
- rs2_value  out  32  Value of physical_rs2; 0 when not ready.

## Operation
- State:
  - RAT: 32 entries of 6 bits.
  - Per physical register: a ready bit and a 32-bit value.
  - Free list: a circular FIFO of 6-bit tags, 64 slots, with head, tail and count.
- Reset state:
  - RAT[i] = i.
  - p0..p31 are ready with value 0; p32..p63 are not ready with value 0.
  - Free list holds p32..p63 in ascending order, with the head at p32.
- One instruction is presented per cycle; there is no valid signal. Its inputs are evaluated combinationally and committed at the next rising edge.
- Source lookup is combinational: physical_rsN = RAT[architectural_rsN].
  - The lookup reads the RAT before this instruction's own rd update, so a source equal to rd sees the old mapping.
- Ready and value are combinational:
  - If wakeup_active and wakeup_tag == physical_rsN and wakeup_tag != 0, then ready = 1 and value = wakeup_value (bypass).
  - Otherwise ready and value come from the stored state.
- p0 is hardwired: always ready, value 0, never allocated, never freed. Wakeups to tag 0 are ignored.
- Allocation: when architectural_rd != 0 and the free list is non-empty, physical_rd = the free-list head.
  - At the edge: RAT[rd] = head, head advances, and the allocated tag's ready bit and value are cleared.
- Free list empty with rd != 0: physical_rd = 0 and no state changes for rd. Stalling is the responsibility of upstream.
- Wakeup at the edge: ready[wakeup_tag] = 1 and value[wakeup_tag] = wakeup_value.
- Frees at the edge: each nonzero freed tag is pushed at the tail, freed_tag_1 first. The count is adjusted for the net of pushes and the pop.
  - Pushes beyond 64 entries are dropped.
  - A freed tag becomes allocatable no earlier than the next cycle.

## Timing
- Lookup, ready/value and physical_rd outputs are combinational: zero latency from inputs.
- RAT, free-list and ready updates take effect at the rising edge and are visible in the following cycle.
- Wakeup-to-ready latency is 0 cycles via bypass; the ready state persists from the next edge onward.
- Same-edge conflict on one tag between allocation clear and wakeup set: allocation wins.
- Reset is asynchronous and overrides any in-flight update. Asserting it mid-operation discards all allocations.

## Test plan
- After reset, present add x1,x0,x1 → physical_rs1 = 0, physical_rs2 = 1, both ready with value 0, physical_rd = 32.
- Next cycle, present add x1,x0,x1 again → physical_rs2 = 32 and not ready; physical_rd = 33; rs1 ready with value 0.
- Next, present add x0,x0,x1 with wakeup of tag 32, value 123 → physical_rs2 = 33 and not ready; physical_rd = 0.
- Next, same instruction with wakeup of tag 33, value 456 → rs2_ready = 1 and rs2_value = 456 in the same cycle.
- Next, same instruction with wakeup_active = 0 → rs2 is still ready with value 456.
- Allocate 32 destinations to exhaust the free list → the 33rd gives physical_rd = 0. Then free tag 40 → the next allocation returns 40.

Source files
------------

// File: rtl/rename.sv
// rename: maps 32 architectural registers onto 64 physical tags, allocates
// destination tags from a circular free list and tracks per-tag ready/value state.
`default_nettype none

module rename (
   input  logic        clk,
   input  logic        reset,
   input  logic        wakeup_active,
   input  logic [5:0]  wakeup_tag,
   input  logic [31:0] wakeup_value,
   input  logic [5:0]  freed_tag_1,
   input  logic [5:0]  freed_tag_2,
   input  logic [4:0]  architectural_rd,
   input  logic [4:0]  architectural_rs1,
   input  logic [4:0]  architectural_rs2,
   output logic [5:0]  physical_rd,
   output logic [5:0]  physical_rs1,
   output logic [5:0]  physical_rs2,
   output logic        rs1_ready,
   output logic        rs2_ready,
   output logic [31:0] rs1_value,
   output logic [31:0] rs2_value
);

   localparam logic [6:0] C_FL_DEPTH = 7'd64;

   logic [5:0]  r_rat   [32];
   logic [63:0] r_ready;
   logic [31:0] r_value [64];
   logic [5:0]  r_fl    [64];
   logic [5:0]  r_head;
   logic [5:0]  r_tail;
   logic [6:0]  r_count;

   logic        w_alloc;
   logic        w_wake;
   logic        w_push1;
   logic        w_push2;
   logic [6:0]  w_cnt_pop;
   logic [6:0]  w_cnt_p1;
   logic [6:0]  w_cnt_next;
   logic [5:0]  w_tail2;
   logic [5:0]  w_tail_next;
   logic        w_byp1;
   logic        w_byp2;

   assign w_alloc = (architectural_rd != 5'd0) && (r_count != 7'd0);
   assign w_wake  = wakeup_active && (wakeup_tag != 6'd0);

   // The pop is accounted before the pushes, so a full list that allocates
   // this cycle still accepts one returned tag.
   assign w_cnt_pop   = r_count - {6'd0, w_alloc};
   assign w_push1     = (freed_tag_1 != 6'd0) && (w_cnt_pop != C_FL_DEPTH);
   assign w_cnt_p1    = w_cnt_pop + {6'd0, w_push1};
   assign w_push2     = (freed_tag_2 != 6'd0) && (w_cnt_p1 != C_FL_DEPTH);
   assign w_cnt_next  = w_cnt_p1 + {6'd0, w_push2};
   assign w_tail2     = w_push1 ? (r_tail + 6'd1) : r_tail;
   assign w_tail_next = w_push2 ? (w_tail2 + 6'd1) : w_tail2;

   assign physical_rd  = w_alloc ? r_fl[r_head] : 6'd0;
   assign physical_rs1 = r_rat[architectural_rs1];
   assign physical_rs2 = r_rat[architectural_rs2];

   assign w_byp1 = w_wake && (wakeup_tag == physical_rs1);
   assign w_byp2 = w_wake && (wakeup_tag == physical_rs2);

   always_comb begin
      rs1_ready = w_byp1 || r_ready[physical_rs1];
      rs2_ready = w_byp2 || r_ready[physical_rs2];
      rs1_value = 32'd0;
      rs2_value = 32'd0;
      if (w_byp1)
         rs1_value = wakeup_value;
      else if (r_ready[physical_rs1])
         rs1_value = r_value[physical_rs1];
      if (w_byp2)
         rs2_value = wakeup_value;
      else if (r_ready[physical_rs2])
         rs2_value = r_value[physical_rs2];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            r_rat[i] <= 6'(i);
         end
         for (int i = 0; i < 64; i++) begin
            r_value[i] <= 32'd0;
            r_fl[i]    <= (i < 32) ? 6'(i + 32) : 6'd0;
         end
         r_ready <= {32'h0000_0000, 32'hFFFF_FFFF};
         r_head  <= 6'd0;
         r_tail  <= 6'd32;
         r_count <= 7'd32;
      end else begin
         if (w_wake) begin
            r_ready[wakeup_tag] <= 1'b1;
            r_value[wakeup_tag] <= wakeup_value;
         end
         // Placed after the wakeup so a same-tag conflict leaves the tag cleared.
         if (w_alloc) begin
            r_rat[architectural_rd] <= r_fl[r_head];
            r_ready[r_fl[r_head]]   <= 1'b0;
            r_value[r_fl[r_head]]   <= 32'd0;
            r_head                  <= r_head + 6'd1;
         end
         if (w_push1)
            r_fl[r_tail] <= freed_tag_1;
         if (w_push2)
            r_fl[w_tail2] <= freed_tag_2;
         r_tail  <= w_tail_next;
         r_count <= w_cnt_next;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rename.sv
// tb_rename: directed and randomized checks of rename against a queue-based model.
`default_nettype none

module tb_rename;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        wa = 1'b0;
   logic [5:0]  wt = '0;
   logic [31:0] wv = '0;
   logic [5:0]  f1 = '0;
   logic [5:0]  f2 = '0;
   logic [4:0]  rd = '0;
   logic [4:0]  rs1 = '0;
   logic [4:0]  rs2 = '0;
   logic [5:0]  prd, prs1, prs2;
   logic        r1, r2;
   logic [31:0] v1, v2;

   int checks = 0;
   int errors = 0;

   // reference model state
   int          m_rat [32];
   bit          m_rdy [64];
   logic [31:0] m_val [64];
   int          m_fl  [$];

   always #5 clk = ~clk;

   rename dut (
      .clk(clk), .reset(reset),
      .wakeup_active(wa), .wakeup_tag(wt), .wakeup_value(wv),
      .freed_tag_1(f1), .freed_tag_2(f2),
      .architectural_rd(rd), .architectural_rs1(rs1), .architectural_rs2(rs2),
      .physical_rd(prd), .physical_rs1(prs1), .physical_rs2(prs2),
      .rs1_ready(r1), .rs2_ready(r2), .rs1_value(v1), .rs2_value(v2)
   );

   task automatic model_reset();
      m_fl.delete();
      for (int i = 0; i < 64; i++) begin
         m_rdy[i] = (i < 32);
         m_val[i] = 32'd0;
         if (i >= 32) m_fl.push_back(i);
      end
      for (int i = 0; i < 32; i++) m_rat[i] = i;
   endtask

   task automatic model_expect(output logic [5:0] e_prd, output logic [5:0] e_p1,
                               output logic [5:0] e_p2, output logic e_r1, output logic e_r2,
                               output logic [31:0] e_v1, output logic [31:0] e_v2);
      bit b1, b2;
      e_prd = (rd != 0 && m_fl.size() > 0) ? 6'(m_fl[0]) : 6'd0;
      e_p1  = 6'(m_rat[rs1]);
      e_p2  = 6'(m_rat[rs2]);
      b1 = wa && wt != 0 && wt == e_p1;
      b2 = wa && wt != 0 && wt == e_p2;
      e_r1 = b1 || m_rdy[e_p1];
      e_r2 = b2 || m_rdy[e_p2];
      e_v1 = b1 ? wv : (m_rdy[e_p1] ? m_val[e_p1] : 32'd0);
      e_v2 = b2 ? wv : (m_rdy[e_p2] ? m_val[e_p2] : 32'd0);
   endtask

   task automatic model_commit();
      int tag;
      if (wa && wt != 0) begin
         m_rdy[wt] = 1'b1;
         m_val[wt] = wv;
      end
      if (rd != 0 && m_fl.size() > 0) begin
         tag = m_fl.pop_front();
         m_rat[rd] = tag;
         m_rdy[tag] = 1'b0;
         m_val[tag] = 32'd0;
      end
      if (f1 != 0 && m_fl.size() < 64) m_fl.push_back(int'(f1));
      if (f2 != 0 && m_fl.size() < 64) m_fl.push_back(int'(f2));
   endtask

   task automatic drive(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic a, input logic [5:0] t, input logic [31:0] v,
                        input logic [5:0] g1, input logic [5:0] g2);
      @(negedge clk);
      rd = d; rs1 = s1; rs2 = s2; wa = a; wt = t; wv = v; f1 = g1; f2 = g2;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_commit();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      rd = '0; rs1 = '0; rs2 = '0; wa = 1'b0; wt = '0; wv = '0; f1 = '0; f2 = '0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      drive(5'd7, 5'd31, 5'd0, 1'b0, 6'd0, 32'd0, 6'd0, 6'd0);
      checks++;
      if (prs1 !== 6'd31 || prs2 !== 6'd0 || r1 !== 1'b1 || r2 !== 1'b1 ||
          v1 !== 32'd0 || v2 !== 32'd0 || prd !== 6'd32) begin
         errors++;
         $display("FAIL reset_state: prs1=%0d prs2=%0d r1=%b r2=%b v1=%0d v2=%0d prd=%0d (want 31 0 1 1 0 0 32)",
                  prs1, prs2, r1, r2, v1, v2, prd);
      end
   endtask

   task automatic test_plan();
      do_reset();
      drive(5'd1, 5'd0, 5'd1, 1'b0, 6'd0, 32'd0, 6'd0, 6'd0);
      checks++;
      if (prs1 !== 6'd0 || prs2 !== 6'd1 || r1 !== 1'b1 || r2 !== 1'b1 ||
          v1 !== 32'd0 || v2 !== 32'd0 || prd !== 6'd32) begin
         errors++;
         $display("FAIL plan_first: prs1=%0d prs2=%0d r1=%b r2=%b prd=%0d (want 0 1 1 1 32)", prs1, prs2, r1, r2, prd);
      end
      tick();
      drive(5'd1, 5'd0, 5'd1, 1'b0, 6'd0, 32'd0, 6'd0, 6'd0);
      checks++;
      if (prs2 !== 6'd32 || r2 !== 1'b0 || v2 !== 32'd0 || prd !== 6'd33 || r1 !== 1'b1 || v1 !== 32'd0) begin
         errors++;
         $display("FAIL plan_second: prs2=%0d r2=%b v2=%0d prd=%0d r1=%b (want 32 0 0 33 1)", prs2, r2, v2, prd, r1);
      end
      tick();
      drive(5'd0, 5'd0, 5'd1, 1'b1, 6'd32, 32'd123, 6'd0, 6'd0);
      checks++;
      if (prs2 !== 6'd33 || r2 !== 1'b0 || prd !== 6'd0) begin
         errors++;
         $display("FAIL plan_wake32: prs2=%0d r2=%b prd=%0d (want 33 0 0)", prs2, r2, prd);
      end
      tick();
      drive(5'd0, 5'd0, 5'd1, 1'b1, 6'd33, 32'd456, 6'd0, 6'd0);
      checks++;
      if (r2 !== 1'b1 || v2 !== 32'd456) begin
         errors++;
         $display("FAIL plan_bypass: r2=%b v2=%0d (want 1 456)", r2, v2);
      end
      tick();
      drive(5'd0, 5'd0, 5'd1, 1'b0, 6'd0, 32'd0, 6'd0, 6'd0);
      checks++;
      if (r2 !== 1'b1 || v2 !== 32'd456) begin
         errors++;
         $display("FAIL plan_persist: r2=%b v2=%0d (want 1 456)", r2, v2);
      end
      tick();
   endtask

   task automatic test_exhaust();
      do_reset();
      for (int i = 0; i < 32; i++) begin
         drive(5'd1, 5'd0, 5'd0, 1'b0, 6'd0, 32'd0, 6'd0, 6'd0);
         checks++;
         if (prd !== 6'(32 + i)) begin
            errors++;
            $display("FAIL exhaust_alloc%0d: prd=%0d want %0d", i, prd, 32 + i);
         end
         tick();
      end
      drive(5'd2, 5'd2, 5'd0, 1'b0, 6'd0, 32'd0, 6'd0, 6'd0);
      checks++;
      if (prd !== 6'd0 || prs1 !== 6'd2) begin
         errors++;
         $display("FAIL exhaust_empty: prd=%0d prs1=%0d (want 0 2)", prd, prs1);
      end
      tick();
      // tag freed this cycle must not be allocatable yet
      drive(5'd3, 5'd2, 5'd0, 1'b0, 6'd0, 32'd0, 6'd40, 6'd0);
      checks++;
      if (prd !== 6'd0) begin
         errors++;
         $display("FAIL exhaust_free_same_cycle: prd=%0d want 0", prd);
      end
      tick();
      drive(5'd2, 5'd3, 5'd0, 1'b0, 6'd0, 32'd0, 6'd0, 6'd0);
      checks++;
      if (prd !== 6'd40 || prs1 !== 6'd3) begin
         errors++;
         $display("FAIL exhaust_realloc: prd=%0d prs1=%0d (want 40 3)", prd, prs1);
      end
      tick();
   endtask

   task automatic test_overflow();
      do_reset();
      // 40 tags offered into 32 free slots: tags 33..40 are dropped
      for (int i = 0; i < 20; i++) begin
         drive(5'd0, 5'd0, 5'd0, 1'b0, 6'd0, 32'd0, 6'(2 * i + 1), 6'(2 * i + 2));
         tick();
      end
      for (int i = 0; i < 65; i++) begin
         drive(5'd4, 5'd0, 5'd0, 1'b0, 6'd0, 32'd0, 6'd0, 6'd0);
         checks++;
         if (prd !== ((i < 32) ? 6'(32 + i) : (i < 64) ? 6'(i - 31) : 6'd0)) begin
            errors++;
            $display("FAIL overflow_alloc%0d: prd=%0d", i, prd);
         end
         tick();
      end
   endtask

   task automatic test_conflict();
      do_reset();
      drive(5'd5, 5'd0, 5'd0, 1'b1, 6'd32, 32'd77, 6'd0, 6'd0);
      checks++;
      if (prd !== 6'd32) begin
         errors++;
         $display("FAIL conflict_alloc: prd=%0d want 32", prd);
      end
      tick();
      drive(5'd0, 5'd5, 5'd0, 1'b1, 6'd0, 32'd99, 6'd0, 6'd0);
      checks++;
      if (prs1 !== 6'd32 || r1 !== 1'b0 || v1 !== 32'd0) begin
         errors++;
         $display("FAIL conflict_alloc_wins: prs1=%0d r1=%b v1=%0d (want 32 0 0)", prs1, r1, v1);
      end
      checks++;
      if (r2 !== 1'b1 || v2 !== 32'd0) begin
         errors++;
         $display("FAIL p0_wakeup_ignored: r2=%b v2=%0d (want 1 0)", r2, v2);
      end
      tick();
   endtask

   task automatic test_random();
      logic [5:0] e_prd, e_p1, e_p2;
      logic e_r1, e_r2;
      logic [31:0] e_v1, e_v2;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         drive(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom(),
               ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 63)) : 6'd0,
               ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 63)) : 6'd0);
         if (i % 7 == 0 && m_rat[rs1] >= 32) begin
            wt = 6'(m_rat[rs1]);
            #1;
         end
         model_expect(e_prd, e_p1, e_p2, e_r1, e_r2, e_v1, e_v2);
         checks++;
         if (prd !== e_prd || prs1 !== e_p1 || prs2 !== e_p2 || r1 !== e_r1 || r2 !== e_r2 ||
             v1 !== e_v1 || v2 !== e_v2) begin
            errors++;
            $display("FAIL random%0d: got prd=%0d p1=%0d p2=%0d r=%b%b v=%h/%h want prd=%0d p1=%0d p2=%0d r=%b%b v=%h/%h",
                     i, prd, prs1, prs2, r1, r2, v1, v2, e_prd, e_p1, e_p2, e_r1, e_r2, e_v1, e_v2);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      rd = 5'd1; rs1 = 5'd1; rs2 = 5'd9; wa = 1'b0; f1 = '0; f2 = '0;
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (prs1 !== 6'd1 || prs2 !== 6'd9 || prd !== 6'd32 || r1 !== 1'b1 || v2 !== 32'd0) begin
         errors++;
         $display("FAIL reset_async: prs1=%0d prs2=%0d prd=%0d r1=%b v2=%0d (want 1 9 32 1 0)", prs1, prs2, prd, r1, v2);
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_plan();
      test_exhaust();
      test_overflow();
      test_conflict();
      test_random();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
